// File: rtl/booth_mult_arbiter_pkg.sv
// Shared definitions for the Booth multiplier arbiter: FSM encoding,
// default sizing and a small index-width helper.
package booth_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 4;
    localparam int TMO_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESULT    = 3'd4
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/booth_mult_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals around the arbiter.
// The slave modport is the arbiter; the master side plays requesters and multiplier.
interface booth_mult_arbiter_if
    import booth_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
);

    logic [NREQ-1:0]          req;
    logic [NREQ*W-1:0]        opa;
    logic [NREQ*W-1:0]        opb;
    logic [NREQ-1:0]          gnt;
    logic [NREQ-1:0]          done;
    logic signed [2*W-1:0]    result;
    logic                     err;

    logic                     mul_start;
    logic signed [W-1:0]      mul_a;
    logic signed [W-1:0]      mul_b;
    logic signed [2*W-1:0]    mul_ab;
    logic                     mul_busy;

    modport slave (
        input  req, opa, opb, mul_ab, mul_busy,
        output gnt, done, result, err, mul_start, mul_a, mul_b
    );

    modport master (
        output req, opa, opb, mul_ab, mul_busy,
        input  gnt, done, result, err, mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/booth_mult_arbiter_rr_pick.sv
// Round-robin selector: first asserted request strictly above ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_pick
    import booth_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        // k = NREQ lands back on ptr itself, so the last winner is considered last
        for (int k = 1; k <= NREQ; k++) begin
            cand = (IW+1)'(ptr) + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!any && req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one external multiplier among NREQ requesters: round-robin pick,
// operand latch, start/busy handshake with timeout, and result return.
module booth_mult_arbiter
    import booth_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_mult_arbiter_if.slave bus
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = $clog2(TMO + 1);

    state_t                  state;
    state_t                  state_nxt;

    logic [IW-1:0]           owner;
    logic [IW-1:0]           ptr;
    logic [NREQ-1:0]         pick_oh;
    logic [IW-1:0]           pick_idx;
    logic                    pick_any;

    logic signed [W-1:0]     sel_a;
    logic signed [W-1:0]     sel_b;
    logic signed [W-1:0]     mul_a_q;
    logic signed [W-1:0]     mul_b_q;
    logic signed [2*W-1:0]   result_q;
    logic                    err_q;

    logic [CW-1:0]           tmo_cnt;
    logic                    tmo_hit;

    logic [NREQ-1:0]         gnt_c;
    logic [NREQ-1:0]         done_c;
    logic                    start_c;
    logic                    err_c;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                sel_a = bus.opa[i*W +: W];
                sel_b = bus.opb[i*W +: W];
            end
        end
    end

    assign tmo_hit = (tmo_cnt == CW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (pick_any) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.mul_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_hit) begin
                    state_nxt = RESULT;
                end
            end
            WAIT_DONE: if (!bus.mul_busy) state_nxt = RESULT;
            RESULT:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // gnt and mul_start share the ISSUE cycle; done is always exclusive of both
    always_comb begin
        gnt_c   = '0;
        done_c  = '0;
        start_c = 1'b0;
        err_c   = 1'b0;
        case (state)
            ISSUE: begin
                gnt_c[owner] = 1'b1;
                start_c      = 1'b1;
            end
            RESULT: begin
                done_c[owner] = 1'b1;
                err_c         = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= '0;
            ptr      <= IW'(NREQ - 1);
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                owner   <= pick_idx;
                ptr     <= pick_idx;
                mul_a_q <= sel_a;
                mul_b_q <= sel_b;
            end
            tmo_cnt <= (state == WAIT_BUSY) ? tmo_cnt + CW'(1) : '0;
            if (state == WAIT_BUSY && !bus.mul_busy && tmo_hit) begin
                result_q <= '0;
                err_q    <= 1'b1;
            end else if (state == WAIT_DONE && !bus.mul_busy) begin
                result_q <= bus.mul_ab;
                err_q    <= 1'b0;
            end
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.done      = done_c;
    assign bus.mul_start = start_c;
    assign bus.err       = err_c;
    assign bus.result    = result_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;

endmodule
